// File: rtl/regfile_write_arbiter_if.sv
// Register-file write-port bundle: pipeline writeback, long-latency handshake,
// arbitrated write port, scoreboard query and status.
interface regfile_write_arbiter_if #(
    parameter int DEPTH = 4
);
    logic                     wb_valid;
    logic [4:0]               wb_reg;
    logic [31:0]              wb_data;
    logic                     lu_valid;
    logic                     lu_ready;
    logic [4:0]               lu_reg;
    logic [31:0]              lu_data;
    logic                     RegWrite;
    logic [4:0]               WriteRegister;
    logic [31:0]              WriteData;
    logic [4:0]               q_reg;
    logic                     q_pending;
    logic                     stall_req;
    logic                     overrun;
    logic [$clog2(DEPTH):0]   fifo_count;

    modport master (
        output wb_valid, wb_reg, wb_data, lu_valid, lu_reg, lu_data, q_reg,
        input  lu_ready, RegWrite, WriteRegister, WriteData, q_pending,
               stall_req, overrun, fifo_count
    );

    modport slave (
        input  wb_valid, wb_reg, wb_data, lu_valid, lu_reg, lu_data, q_reg,
        output lu_ready, RegWrite, WriteRegister, WriteData, q_pending,
               stall_req, overrun, fifo_count
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the MIPS register-file write port between the pipeline writeback
// stage (priority) and a FIFO of long-latency results, with starvation stall.
module regfile_write_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input logic                    clk,
    input logic                    reset,
    regfile_write_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [4:0]    regMem  [DEPTH];
    logic [31:0]   dataMem [DEPTH];
    logic [PW-1:0] rdPtr, wrPtr;
    logic [CW-1:0] fifoCount, nextCount;
    logic [SW-1:0] starveCnt, nextStarve;
    logic          stallReq, overrunFlag;
    logic          regWriteQ;
    logic [4:0]    writeRegQ;
    logic [31:0]   writeDataQ;
    logic          fifoEmpty, fifoFull, wbAct, enq, forceDeq, wbGrant, deq, drop;
    logic          qHit;

    always_comb begin
        fifoEmpty = (fifoCount == '0);
        fifoFull  = (fifoCount == CW'(DEPTH));
        wbAct     = bus.wb_valid && (bus.wb_reg != 5'd0);
        // Register-0 results complete the handshake but are never stored.
        enq       = bus.lu_valid && !fifoFull && (bus.lu_reg != 5'd0);
        forceDeq  = stallReq && !fifoEmpty;
        wbGrant   = wbAct && !forceDeq;
        deq       = forceDeq || (!wbAct && !fifoEmpty);
        drop      = forceDeq && wbAct;
        nextCount = fifoCount + CW'(enq) - CW'(deq);
        if (deq || fifoEmpty)
            nextStarve = '0;
        else if (wbGrant && (starveCnt < LIMIT))
            nextStarve = starveCnt + SW'(1);
        else
            nextStarve = starveCnt;
    end

    // Only occupied slots, counted from the head, take part in the query.
    always_comb begin
        qHit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < fifoCount) && (regMem[rdPtr + PW'(i)] == bus.q_reg))
                qHit = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr       <= '0;
            wrPtr       <= '0;
            fifoCount   <= '0;
            starveCnt   <= '0;
            stallReq    <= 1'b0;
            overrunFlag <= 1'b0;
            regWriteQ   <= 1'b0;
            writeRegQ   <= '0;
            writeDataQ  <= '0;
        end else begin
            if (enq) wrPtr <= wrPtr + PW'(1);
            if (deq) rdPtr <= rdPtr + PW'(1);
            fifoCount <= nextCount;
            starveCnt <= nextStarve;
            stallReq  <= (nextStarve >= LIMIT) && (nextCount != '0);
            if (drop) overrunFlag <= 1'b1;
            regWriteQ <= wbGrant || deq;
            if (wbGrant) begin
                writeRegQ  <= bus.wb_reg;
                writeDataQ <= bus.wb_data;
            end else if (deq) begin
                writeRegQ  <= regMem[rdPtr];
                writeDataQ <= dataMem[rdPtr];
            end
        end
    end

    // Storage is qualified by fifoCount, so it needs no reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            regMem[wrPtr]  <= bus.lu_reg;
            dataMem[wrPtr] <= bus.lu_data;
        end
    end

    assign bus.lu_ready      = !fifoFull;
    assign bus.q_pending     = qHit && (bus.q_reg != 5'd0);
    assign bus.RegWrite      = regWriteQ;
    assign bus.WriteRegister = writeRegQ;
    assign bus.WriteData     = writeDataQ;
    assign bus.stall_req     = stallReq;
    assign bus.overrun       = overrunFlag;
    assign bus.fifo_count    = fifoCount;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: priority, FIFO ordering and wrap,
// starvation stall, overrun, register-0 handling and asynchronous reset.
module tb_regfile_write_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    regfile_write_arbiter_if #(.DEPTH(4)) bus ();

    regfile_write_arbiter #(.DEPTH(4), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wb_valid = 1'b0; bus.wb_reg = 5'd0; bus.wb_data = 32'd0;
        bus.lu_valid = 1'b0; bus.lu_reg = 5'd0; bus.lu_data = 32'd0;
        bus.q_reg = 5'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        tick(); tick();
        checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL rst_we got=%0b exp=0", bus.RegWrite); end
        checks++; if (bus.WriteRegister !== 5'd0) begin errors++; $display("FAIL rst_wr got=%0d exp=0", bus.WriteRegister); end
        checks++; if (bus.WriteData !== 32'd0) begin errors++; $display("FAIL rst_wd got=%h exp=0", bus.WriteData); end
        checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", bus.fifo_count); end
        checks++; if (bus.lu_ready !== 1'b1) begin errors++; $display("FAIL rst_rdy got=%0b exp=1", bus.lu_ready); end
        checks++; if ({bus.stall_req, bus.overrun, bus.q_pending} !== 3'b000) begin errors++; $display("FAIL rst_flags got=%b exp=000", {bus.stall_req, bus.overrun, bus.q_pending}); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_pipeline();
        bus.wb_valid = 1'b1; bus.wb_reg = 5'd5; bus.wb_data = 32'hDEADBEEF;
        tick();
        checks++; if ({bus.RegWrite, bus.WriteRegister, bus.WriteData} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin errors++; $display("FAIL pipe_write got=%0b/%0d/%h exp=1/5/deadbeef", bus.RegWrite, bus.WriteRegister, bus.WriteData); end
        bus.wb_reg = 5'd0; bus.wb_data = 32'h12345678;
        tick();
        checks++; if ({bus.RegWrite, bus.WriteRegister, bus.WriteData} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin errors++; $display("FAIL pipe_reg0_hold got=%0b/%0d/%h exp=0/5/deadbeef", bus.RegWrite, bus.WriteRegister, bus.WriteData); end
        idle_inputs();
        tick();
    endtask

    task automatic test_drain();
        bus.lu_valid = 1'b1; bus.lu_reg = 5'd7; bus.lu_data = 32'h11; bus.q_reg = 5'd7;
        #1;
        checks++; if (bus.q_pending !== 1'b0) begin errors++; $display("FAIL drain_enq_invisible got=%0b exp=0", bus.q_pending); end
        tick();
        bus.lu_reg = 5'd8; bus.lu_data = 32'h22; bus.q_reg = 5'd7;
        #1;
        checks++; if ({bus.fifo_count, bus.q_pending} !== {3'd1, 1'b1}) begin errors++; $display("FAIL drain_first got=%0d/%0b exp=1/1", bus.fifo_count, bus.q_pending); end
        tick();
        bus.lu_valid = 1'b0; bus.q_reg = 5'd8;
        #1;
        checks++; if ({bus.RegWrite, bus.WriteRegister, bus.WriteData} !== {1'b1, 5'd7, 32'h11}) begin errors++; $display("FAIL drain_w7 got=%0b/%0d/%h exp=1/7/11", bus.RegWrite, bus.WriteRegister, bus.WriteData); end
        checks++; if ({bus.fifo_count, bus.q_pending} !== {3'd1, 1'b1}) begin errors++; $display("FAIL drain_pend8 got=%0d/%0b exp=1/1", bus.fifo_count, bus.q_pending); end
        tick();
        checks++; if ({bus.RegWrite, bus.WriteRegister, bus.WriteData} !== {1'b1, 5'd8, 32'h22}) begin errors++; $display("FAIL drain_w8 got=%0b/%0d/%h exp=1/8/22", bus.RegWrite, bus.WriteRegister, bus.WriteData); end
        checks++; if ({bus.fifo_count, bus.q_pending} !== {3'd0, 1'b0}) begin errors++; $display("FAIL drain_clear got=%0d/%0b exp=0/0", bus.fifo_count, bus.q_pending); end
        tick();
        checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL drain_idle got=%0b exp=0", bus.RegWrite); end
        idle_inputs();
    endtask

    task automatic test_full_wrap();
        bus.wb_valid = 1'b1; bus.wb_reg = 5'd3; bus.wb_data = 32'h33;
        for (int i = 0; i < 4; i++) begin
            bus.lu_valid = 1'b1; bus.lu_reg = 5'(10 + i); bus.lu_data = 32'h100 + 32'(i);
            tick();
        end
        bus.lu_reg = 5'd14; bus.lu_data = 32'h104; bus.wb_valid = 1'b0;
        #1;
        checks++; if ({bus.fifo_count, bus.lu_ready} !== {3'd4, 1'b0}) begin errors++; $display("FAIL full_state got=%0d/%0b exp=4/0", bus.fifo_count, bus.lu_ready); end
        checks++; if ({bus.RegWrite, bus.WriteRegister} !== {1'b1, 5'd3}) begin errors++; $display("FAIL full_wb_prio got=%0b/%0d exp=1/3", bus.RegWrite, bus.WriteRegister); end
        tick();
        bus.lu_valid = 1'b0;
        checks++; if ({bus.fifo_count, bus.WriteRegister, bus.WriteData} !== {3'd3, 5'd10, 32'h100}) begin errors++; $display("FAIL full_held_off got=%0d/%0d/%h exp=3/10/100", bus.fifo_count, bus.WriteRegister, bus.WriteData); end
        for (int i = 1; i < 4; i++) begin
            tick();
            checks++; if ({bus.RegWrite, bus.WriteRegister, bus.WriteData} !== {1'b1, 5'(10 + i), 32'h100 + 32'(i)}) begin errors++; $display("FAIL full_drain%0d got=%0b/%0d/%h exp=1/%0d/%h", i, bus.RegWrite, bus.WriteRegister, bus.WriteData, 10 + i, 32'h100 + 32'(i)); end
        end
        checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL full_empty got=%0d exp=0", bus.fifo_count); end
        for (int i = 0; i < 4; i++) begin
            bus.lu_valid = 1'b1; bus.lu_reg = 5'(20 + i); bus.lu_data = 32'h200 + 32'(i);
            tick();
            if (i >= 1) begin
                checks++; if ({bus.RegWrite, bus.WriteRegister, bus.WriteData} !== {1'b1, 5'(19 + i), 32'h1FF + 32'(i)}) begin errors++; $display("FAIL wrap%0d got=%0b/%0d/%h exp=1/%0d/%h", i, bus.RegWrite, bus.WriteRegister, bus.WriteData, 19 + i, 32'h1FF + 32'(i)); end
            end
        end
        bus.lu_valid = 1'b0;
        tick();
        checks++; if ({bus.RegWrite, bus.WriteRegister, bus.WriteData, bus.fifo_count} !== {1'b1, 5'd23, 32'h203, 3'd0}) begin errors++; $display("FAIL wrap_last got=%0b/%0d/%h/%0d exp=1/23/203/0", bus.RegWrite, bus.WriteRegister, bus.WriteData, bus.fifo_count); end
        idle_inputs();
        tick();
    endtask

    task automatic test_reg0();
        bus.lu_valid = 1'b1; bus.lu_reg = 5'd0; bus.lu_data = 32'hBAD;
        bus.wb_valid = 1'b1; bus.wb_reg = 5'd0; bus.wb_data = 32'hBAD;
        #1;
        checks++; if (bus.lu_ready !== 1'b1) begin errors++; $display("FAIL reg0_ready got=%0b exp=1", bus.lu_ready); end
        tick();
        idle_inputs();
        #1;
        checks++; if ({bus.fifo_count, bus.RegWrite, bus.q_pending} !== {3'd0, 1'b0, 1'b0}) begin errors++; $display("FAIL reg0_noop got=%0d/%0b/%0b exp=0/0/0", bus.fifo_count, bus.RegWrite, bus.q_pending); end
        tick();
        checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL reg0_nowrite got=%0b exp=0", bus.RegWrite); end
    endtask

    task automatic test_starvation(input bit keepWb, input logic [31:0] luData);
        bus.lu_valid = 1'b1; bus.lu_reg = 5'd9; bus.lu_data = luData;
        bus.wb_valid = 1'b1; bus.wb_reg = 5'd4; bus.wb_data = 32'h44;
        tick();
        bus.lu_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++; if ({bus.stall_req, bus.WriteRegister} !== {(i == 4), 5'd4}) begin errors++; $display("FAIL starve%0d got=%0b/%0d exp=%0b/4", i, bus.stall_req, bus.WriteRegister, i == 4); end
        end
        bus.wb_valid = keepWb; bus.wb_data = 32'h55;
        tick();
        checks++; if ({bus.RegWrite, bus.WriteRegister, bus.WriteData, bus.stall_req} !== {1'b1, 5'd9, luData, 1'b0}) begin errors++; $display("FAIL starve_forced got=%0b/%0d/%h/%0b exp=1/9/%h/0", bus.RegWrite, bus.WriteRegister, bus.WriteData, bus.stall_req, luData); end
        checks++; if (bus.overrun !== keepWb) begin errors++; $display("FAIL starve_overrun got=%0b exp=%0b", bus.overrun, keepWb); end
        tick();
        checks++; if ({bus.RegWrite, bus.WriteRegister} !== {keepWb, keepWb ? 5'd4 : 5'd9}) begin errors++; $display("FAIL starve_after got=%0b/%0d exp=%0b", bus.RegWrite, bus.WriteRegister, keepWb); end
        idle_inputs();
        tick();
        checks++; if (bus.overrun !== keepWb) begin errors++; $display("FAIL starve_sticky got=%0b exp=%0b", bus.overrun, keepWb); end
    endtask

    task automatic test_reset_midstream();
        bus.wb_valid = 1'b1; bus.wb_reg = 5'd2; bus.wb_data = 32'h22;
        for (int i = 0; i < 3; i++) begin
            bus.lu_valid = 1'b1; bus.lu_reg = 5'(15 + i); bus.lu_data = 32'h300 + 32'(i);
            tick();
        end
        idle_inputs();
        bus.q_reg = 5'd16;
        #1;
        checks++; if ({bus.fifo_count, bus.q_pending} !== {3'd3, 1'b1}) begin errors++; $display("FAIL mid_filled got=%0d/%0b exp=3/1", bus.fifo_count, bus.q_pending); end
        #1 reset = 1'b1;
        #1;
        checks++; if ({bus.fifo_count, bus.RegWrite, bus.lu_ready, bus.q_pending} !== {3'd0, 1'b0, 1'b1, 1'b0}) begin errors++; $display("FAIL mid_reset got=%0d/%0b/%0b/%0b exp=0/0/1/0", bus.fifo_count, bus.RegWrite, bus.lu_ready, bus.q_pending); end
        checks++; if ({bus.overrun, bus.WriteRegister, bus.WriteData} !== {1'b0, 5'd0, 32'd0}) begin errors++; $display("FAIL mid_reset_regs got=%0b/%0d/%h exp=0/0/0", bus.overrun, bus.WriteRegister, bus.WriteData); end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({bus.RegWrite, bus.fifo_count} !== {1'b0, 3'd0}) begin errors++; $display("FAIL mid_stale%0d got=%0b/%0d exp=0/0", i, bus.RegWrite, bus.fifo_count); end
        end
    endtask

    initial begin
        test_reset();
        test_pipeline();
        test_drain();
        test_full_wrap();
        test_reg0();
        test_starvation(1'b0, 32'h99);
        test_starvation(1'b1, 32'h98);
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Drives the single write port of the 32x32 MIPS register file (RegWrite, WriteRegister, WriteData) from two producers. Producer one is the in-order pipeline writeback stage, which has priority. Producer two is a long-latency unit (multiply/divide, uncached load) with a valid/ready handshake; its results go through a DEPTH-entry FIFO. The block also provides a pending-write scoreboard query for hazard detection and a starvation-driven pipeline stall request.

Parameters:
DEPTH, 4, long-latency FIFO entries; power of two, >=2
STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO may lose arbitration before stall_req asserts

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
wb_valid  input  1  pipeline writeback request this cycle (no back-pressure)
wb_reg  input  5  pipeline destination register
wb_data  input  32  pipeline result
lu_valid  input  1  long-latency result offered
lu_ready  output  1  FIFO can accept; combinational = !full
lu_reg  input  5  long-latency destination register
lu_data  input  32  long-latency result
RegWrite  output  1  registered write enable to register file
WriteRegister  output  5  registered write address
WriteData  output  32  registered write data
q_reg  input  5  scoreboard query register
q_pending  output  1  combinational; 1 if any valid FIFO entry targets q_reg (always 0 for q_reg=0)
stall_req  output  1  registered; pipeline must hold wb_valid low while 1
overrun  output  1  sticky error flag; set if wb write is dropped
fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, any time, including mid-operation): RegWrite=0, WriteRegister=0, WriteData=0, stall_req=0, overrun=0, FIFO emptied (fifo_count=0), starve counter=0. Consequences: lu_ready=1 and q_pending=0 while reset is held and after it.
- Effective wb request: wb_act = wb_valid && wb_reg!=0. A wb_valid with wb_reg=0 is a no-op: it never claims the port and is never flagged.
- Enqueue: on lu_valid && lu_ready. If lu_reg!=0, the entry is written at the tail. If lu_reg=0, the handshake completes and the data is discarded.
- Full FIFO: lu_ready=0 even if a dequeue happens the same cycle. No same-cycle pass-through when full.
- Grant each cycle, evaluated in order:
  1. stall_req=1 and FIFO non-empty: the FIFO head is written. If wb_act is also 1, the wb write is dropped and overrun is set, sticky until reset.
  2. Otherwise, wb_act=1: the wb write is granted.
  3. Otherwise, FIFO non-empty: the FIFO head is written and dequeued.
  4. Otherwise: no write.
- Output latency: the granted write appears on RegWrite/WriteRegister/WriteData exactly one cycle after the request. RegWrite=0 on no-write cycles. WriteRegister and WriteData hold their last values when RegWrite=0.
- Enqueue to write: an entry enqueued in cycle N can be dequeued at the earliest in cycle N+1, so it reaches the port output at N+2.
- Same-cycle enqueue and dequeue when not full: both take effect and fifo_count is unchanged.
- Ordering: FIFO entries are written strictly in arrival order. A wb write to the same register as a queued entry is not reordered; software and hazard logic use q_pending to avoid WAW conflicts.
- q_pending:
  - OR over all valid entries of (entry.reg == q_reg).
  - An entry stops counting in the cycle after it is dequeued.
  - An entry being enqueued this cycle is not visible until the next cycle.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) each cycle the FIFO is non-empty and the wb write is granted.
  - Clears on any FIFO dequeue or when the FIFO is empty.
- stall_req: a register loaded each cycle with (next starve count >= STARVE_LIMIT) && FIFO non-empty after this cycle's update. It drops in the cycle after the FIFO drains, or after the next dequeue if the count clears below the limit.
- Pointer wrap: read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty is determined by fifo_count.

Test Plan:
- Reset mid-stream: fill 3 entries, assert reset -> immediately fifo_count=0, RegWrite=0, lu_ready=1, q_pending=0. After release, no stale writes appear.
- Pipeline only: wb_valid=1, wb_reg=5, wb_data=0xDEADBEEF at cycle N -> RegWrite=1, WriteRegister=5, WriteData=0xDEADBEEF at N+1. Then wb_reg=0 -> RegWrite=0 next cycle.
- Long-latency drain: enqueue (7,0x11),(8,0x22) on idle pipeline -> writes appear in order at N+2 and N+3. q_reg=8 pending=1 until the cycle after its dequeue.
- Full and wrap: hold wb_act=1 and push 4 entries -> lu_ready=0, fifo_count=4. A 5th lu_valid is held off. Release wb, drain, then push 4 more -> written in order across the pointer wrap.
- Starvation: 1 entry queued, wb_act=1 continuously -> stall_req=1 after STARVE_LIMIT=4 cycles. Bench drops wb_valid -> the entry is written and stall_req falls. Repeat keeping wb_valid=1 during stall -> entry written, wb write dropped, overrun=1 sticky.
- Register 0: lu_valid with lu_reg=0 -> handshake completes, fifo_count unchanged, no write. q_reg=0 -> q_pending=0.
